// File: rtl/rx_byte_fifo.sv
// Receive-side byte sink: aligns on COM, filters COM/IDLE, buffers payload in a show-ahead FIFO.
// Optional saturating dropped-byte counter enabled by defining RX_DROP_CNT_EN.
module rx_byte_fifo #(
    parameter int         DEPTH    = 8,
    parameter logic [7:0] COM_SYM  = 8'hBC,
    parameter logic [7:0] IDLE_SYM = 8'h7C
) (
    input  logic                     clk_4f,
    input  logic                     reset,
    input  logic                     active_serial_paraleloTX,
    input  logic [7:0]               data_serial_paraleloTX,
    input  logic                     pop,
    output logic [7:0]               data_out,
    output logic                     valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [1:0]               state
`ifdef RX_DROP_CNT_EN
    ,
    output logic [7:0]               drop_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_INACTIVE = 2'd0,
        ST_ALIGN    = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    state_t        cur_state;
    state_t        next_state;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] occupancy;
    logic          payload;
    logic          do_push;
    logic          do_pop;
    logic          do_drop;

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            cur_state <= ST_INACTIVE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Losing lane lock overrides every other transition.
    always_comb begin
        next_state = cur_state;
        payload    = 1'b0;
        case (cur_state)
            ST_INACTIVE: begin
                if (active_serial_paraleloTX) begin
                    next_state = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (active_serial_paraleloTX && data_serial_paraleloTX == COM_SYM) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                payload = active_serial_paraleloTX &&
                          data_serial_paraleloTX != COM_SYM &&
                          data_serial_paraleloTX != IDLE_SYM;
            end
            default: begin
                next_state = ST_INACTIVE;
            end
        endcase
        if (!active_serial_paraleloTX) begin
            next_state = ST_INACTIVE;
        end
    end

    // A full FIFO still accepts a byte when the head leaves on the same edge.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = payload && (!full || do_pop);
        do_drop = payload && full && !do_pop;
    end

    assign empty    = (occupancy == '0);
    assign full     = (occupancy == FULL_LEVEL);
    assign valid    = !empty;
    assign count    = occupancy;
    assign data_out = mem[rd_ptr];
    assign state    = cur_state;

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= data_serial_paraleloTX;
        end
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + CW'(1);
                2'b01:   occupancy <= occupancy - CW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (do_drop) begin
            overflow <= 1'b1;
        end
    end

`ifdef RX_DROP_CNT_EN
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            drop_count <= 8'h00;
        end else if (do_drop && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Self-checking bench for rx_byte_fifo: directed scenarios plus randomized traffic against a queue model.
// Checks drop_count only when RX_DROP_CNT_EN is defined.
module tb_rx_byte_fifo;

    localparam int DEPTH = 8;

    logic       clk_4f;
    logic       reset;
    logic       active;
    logic [7:0] data_in;
    logic       pop;
    logic [7:0] data_out;
    logic       valid;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;
    logic [1:0] state;
`ifdef RX_DROP_CNT_EN
    logic [7:0] drop_count;
`endif

    int checks;
    int failures;

    // Reference model: FIFO as a queue, FSM state as an integer
    logic [7:0] model_q [$];
    int         model_state;
    bit         model_ovf;
    int         model_drops;

    rx_byte_fifo #(
        .DEPTH    (DEPTH),
        .COM_SYM  (8'hBC),
        .IDLE_SYM (8'h7C)
    ) dut (
        .clk_4f                   (clk_4f),
        .reset                    (reset),
        .active_serial_paraleloTX (active),
        .data_serial_paraleloTX   (data_in),
        .pop                      (pop),
        .data_out                 (data_out),
        .valid                    (valid),
        .full                     (full),
        .empty                    (empty),
        .count                    (count),
        .overflow                 (overflow),
        .state                    (state)
`ifdef RX_DROP_CNT_EN
        ,
        .drop_count               (drop_count)
`endif
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    task automatic do_reset();
        active  = 1'b0;
        data_in = 8'h00;
        pop     = 1'b0;
        #2 reset = 1'b0;
        #3 reset = 1'b1;
        model_q.delete();
        model_state = 0;
        model_ovf   = 1'b0;
        model_drops = 0;
    endtask

    // Drive one cycle of inputs, clock it, then advance the model from its pre-edge view
    task automatic step(input logic a, input logic [7:0] d, input logic p);
        bit eff_pop;
        bit is_payload;
        int size_before;
        active  = a;
        data_in = d;
        pop     = p;
        @(posedge clk_4f);
        #1;
        size_before = model_q.size();
        eff_pop     = p && (size_before > 0);
        is_payload  = (model_state == 2) && a && (d != 8'hBC) && (d != 8'h7C);
        if (eff_pop) begin
            void'(model_q.pop_front());
        end
        if (is_payload) begin
            if (size_before < DEPTH || eff_pop) begin
                model_q.push_back(d);
            end else begin
                model_ovf = 1'b1;
                if (model_drops < 255) model_drops++;
            end
        end
        if (!a) model_state = 0;
        else if (model_state == 0) model_state = 1;
        else if (model_state == 1 && d == 8'hBC) model_state = 2;
    endtask

    task automatic go_run();
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'hBC, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (state !== 2'd0 || empty !== 1'b1 || valid !== 1'b0 || full !== 1'b0 ||
            count !== 4'd0 || overflow !== 1'b0 || data_out !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_state: state=%0d empty=%b valid=%b full=%b count=%0d ovf=%b data=%h, required 0 1 0 0 0 0 00",
                     state, empty, valid, full, count, overflow, data_out);
        end
`ifdef RX_DROP_CNT_EN
        checks++;
        if (drop_count !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_drop_count: got %0d required 0", drop_count);
        end
`endif
    endtask

    task automatic test_inactive();
        do_reset();
        step(1'b0, 8'h11, 1'b0);
        step(1'b0, 8'h22, 1'b0);
        checks++;
        if (state !== 2'd0 || empty !== 1'b1 || count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL inactive_ignore: state=%0d empty=%b count=%0d, required 0 1 0", state, empty, count);
        end
    endtask

    task automatic test_align_filter();
        do_reset();
        step(1'b1, 8'hBC, 1'b0);
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("[TB] FAIL align_state: got %0d required 1", state);
        end
        step(1'b1, 8'hBC, 1'b0);
        checks++;
        if (state !== 2'd2 || count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL run_state: state=%0d count=%0d, required 2 0", state, count);
        end
        step(1'b1, 8'h5A, 1'b0);
        checks++;
        if (valid !== 1'b1 || data_out !== 8'h5A) begin
            failures++;
            $display("[TB] FAIL first_push_latency: valid=%b data=%h, required 1 5a", valid, data_out);
        end
        step(1'b1, 8'h7C, 1'b0);
        step(1'b1, 8'hA5, 1'b0);
        checks++;
        if (count !== 4'd2 || data_out !== 8'h5A) begin
            failures++;
            $display("[TB] FAIL filter_count: count=%0d data=%h, required 2 5a", count, data_out);
        end
        step(1'b1, 8'h7C, 1'b1);
        checks++;
        if (count !== 4'd1 || data_out !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL pop_show_ahead: count=%0d data=%h, required 1 a5", count, data_out);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        go_run();
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i == 8) begin
                checks++;
                if (full !== 1'b1 || overflow !== 1'b0 || count !== 4'd8) begin
                    failures++;
                    $display("[TB] FAIL full_at_8: full=%b ovf=%b count=%0d, required 1 0 8", full, overflow, count);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1 || count !== 4'd8) begin
            failures++;
            $display("[TB] FAIL overflow_set: ovf=%b count=%0d, required 1 8", overflow, count);
        end
`ifdef RX_DROP_CNT_EN
        checks++;
        if (drop_count !== 8'd1) begin
            failures++;
            $display("[TB] FAIL drop_count_one: got %0d required 1", drop_count);
        end
`endif
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (data_out !== 8'(i)) begin
                failures++;
                $display("[TB] FAIL drain_order_%0d: got %h required %h", i, data_out, 8'(i));
            end
            step(1'b1, 8'h7C, 1'b1);
        end
        checks++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            failures++;
            $display("[TB] FAIL drain_end: empty=%b ovf=%b, required 1 1", empty, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        go_run();
        for (int i = 0; i < 8; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
        step(1'b1, 8'h77, 1'b1);
        checks++;
        if (count !== 4'd8 || overflow !== 1'b0 || full !== 1'b1 || data_out !== 8'h11) begin
            failures++;
            $display("[TB] FAIL full_push_pop: count=%0d ovf=%b full=%b data=%h, required 8 0 1 11",
                     count, overflow, full, data_out);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (data_out !== 8'h11 + 8'(i)) begin
                failures++;
                $display("[TB] FAIL wrap_order_%0d: got %h required %h", i, data_out, 8'h11 + 8'(i));
            end
            step(1'b1, 8'h7C, 1'b1);
        end
        checks++;
        if (data_out !== 8'h77 || count !== 4'd1) begin
            failures++;
            $display("[TB] FAIL wrap_last: data=%h count=%0d, required 77 1", data_out, count);
        end
    endtask

    task automatic test_inactive_retain_async_reset();
        do_reset();
        go_run();
        step(1'b1, 8'h31, 1'b0);
        step(1'b1, 8'h32, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        step(1'b0, 8'h34, 1'b0);
        checks++;
        if (state !== 2'd0 || count !== 4'd3 || data_out !== 8'h31) begin
            failures++;
            $display("[TB] FAIL inactive_retain: state=%0d count=%0d data=%h, required 0 3 31", state, count, data_out);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || valid !== 1'b0 || data_out !== 8'h00) begin
            failures++;
            $display("[TB] FAIL async_reset: count=%0d empty=%b valid=%b data=%h, required 0 1 0 00",
                     count, empty, valid, data_out);
        end
        #2 reset = 1'b1;
        model_q.delete();
        model_state = 0;
        model_ovf   = 1'b0;
        model_drops = 0;
    endtask

    task automatic test_pop_empty();
        do_reset();
        go_run();
        step(1'b1, 8'h7C, 1'b1);
        step(1'b1, 8'hBC, 1'b1);
        checks++;
        if (count !== 4'd0 || valid !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pop_empty: count=%0d valid=%b empty=%b, required 0 0 1", count, valid, empty);
        end
        step(1'b1, 8'h9E, 1'b0);
        checks++;
        if (data_out !== 8'h9E || count !== 4'd1) begin
            failures++;
            $display("[TB] FAIL pop_empty_ptr: data=%h count=%0d, required 9e 1", data_out, count);
        end
    endtask

    task automatic test_random();
        logic       a;
        logic       p;
        logic [7:0] d;
        int         pop_bias;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            pop_bias = (cyc / 100) % 3;
            a = ($urandom_range(0, 19) != 0);
            case ($urandom_range(0, 5))
                0:       d = 8'hBC;
                1:       d = 8'h7C;
                default: d = 8'($urandom);
            endcase
            case (pop_bias)
                0:       p = ($urandom_range(0, 3) == 0);
                1:       p = ($urandom_range(0, 3) != 0);
                default: p = $urandom_range(0, 1) == 1;
            endcase
            step(a, d, p);
            checks++;
            if (state !== 2'(model_state) || count !== 4'(model_q.size()) ||
                empty !== (model_q.size() == 0) || full !== (model_q.size() == DEPTH) ||
                valid !== (model_q.size() != 0) || overflow !== model_ovf) begin
                failures++;
                $display("[TB] FAIL random_status cyc=%0d: state=%0d count=%0d empty=%b full=%b valid=%b ovf=%b, required state=%0d count=%0d ovf=%b",
                         cyc, state, count, empty, full, valid, overflow, model_state, model_q.size(), model_ovf);
            end
            if (model_q.size() != 0) begin
                checks++;
                if (data_out !== model_q[0]) begin
                    failures++;
                    $display("[TB] FAIL random_data cyc=%0d: got %h required %h", cyc, data_out, model_q[0]);
                end
            end
`ifdef RX_DROP_CNT_EN
            checks++;
            if (drop_count !== 8'(model_drops)) begin
                failures++;
                $display("[TB] FAIL random_drop_count cyc=%0d: got %0d required %0d", cyc, drop_count, model_drops);
            end
`endif
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        active   = 1'b0;
        data_in  = 8'h00;
        pop      = 1'b0;
        #1;
        test_reset();
        test_inactive();
        test_align_filter();
        test_overflow();
        test_full_push_pop();
        test_inactive_retain_async_reset();
        test_pop_empty();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
